// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          INST_BYTES = 4;
  localparam int          CNT_W      = 3;
  // Instruction IF substitutes while a redirect is in progress.
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

endpackage

// File: rtl/ifetch_lastbuf.sv
// ifetch_lastbuf: one-entry {valid, tag, word} buffer of the last completed fetch.
module ifetch_lastbuf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        upd_i,
  input  logic [31:0] tag_i,
  input  logic [31:0] word_i,
  input  logic [31:0] look_i,
  output logic        hit_o,
  output logic [31:0] word_o
);

  logic        valid_q;
  logic [31:0] tag_q;
  logic [31:0] word_q;

  // Valid bit is control: cleared by reset, set by every completed fetch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else if (upd_i) begin
      valid_q <= 1'b1;
    end
  end

  // Tag and word are plain data storage, qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (upd_i) begin
      tag_q  <= tag_i;
      word_q <= word_i;
    end
  end

  assign hit_o  = valid_q && (tag_q == look_i);
  assign word_o = word_q;

endmodule

// File: rtl/ifetch_mem.sv
// ifetch_mem: fetches a 32-bit instruction as four little-endian bytes from an
// 8-bit synchronous-read RAM. Optional last-fetch buffer: IFETCH_LASTBUF_EN.
module ifetch_mem
  import ifetch_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        ok,
  output logic [31:0] dt,
  output logic        busy,
  output logic [31:0] mem_a,
  output logic        mem_rd,
  input  logic [7:0]  mem_din
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   icnt_q, icnt_d;
  logic [CNT_W-1:0]   ccnt_q, ccnt_d;
  logic [31:0]        base_q, base_d;
  logic [31:0]        asm_q, asm_d;
  logic [31:0]        dt_q, dt_d;
  logic               ok_q, ok_d;

  logic [31:0]        req_base;
  logic               issue;
  logic               capture;
  logic               hit;
  logic [31:0]        hit_word;
  logic               unused_pc;

  // Byte offset within the word is irrelevant: fetches are always word aligned.
  assign req_base  = {pc[31:2], 2'b00};
  assign unused_pc = ^pc[1:0];

  // A byte is returned RAM_LAT cycles after its address, so capture trails issue.
  assign issue   = (state_q == READ) && (icnt_q < CNT_W'(INST_BYTES));
  assign capture = (state_q == READ) && (int'(icnt_q) >= int'(ccnt_q) + RAM_LAT);

`ifdef IFETCH_LASTBUF_EN
  logic lb_upd;
  assign lb_upd = (state_q == DONE) && !flush;

  ifetch_lastbuf u_lastbuf (
    .clk_i  (clk),
    .rst_ni (rst),
    .upd_i  (lb_upd),
    .tag_i  (base_q),
    .word_i (asm_q),
    .look_i (req_base),
    .hit_o  (hit),
    .word_o (hit_word)
  );
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

  // Next-state and datapath update; flush overrides everything, including req.
  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    ccnt_d  = ccnt_q;
    base_d  = base_q;
    asm_d   = asm_q;
    dt_d    = dt_q;
    ok_d    = 1'b0;
    if (flush) begin
      state_d = IDLE;
      icnt_d  = '0;
      ccnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              ok_d = 1'b1;
              dt_d = hit_word;
            end else begin
              state_d = READ;
              base_d  = req_base;
              icnt_d  = '0;
              ccnt_d  = '0;
            end
          end
        end
        READ: begin
          if (issue) begin
            icnt_d = icnt_q + CNT_W'(1);
          end
          if (capture) begin
            asm_d[{ccnt_q[1:0], 3'b000} +: 8] = mem_din;
            ccnt_d = ccnt_q + CNT_W'(1);
            if (ccnt_q == CNT_W'(INST_BYTES - 1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          ok_d    = 1'b1;
          dt_d    = asm_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      icnt_q  <= '0;
      ccnt_q  <= '0;
      ok_q    <= 1'b0;
      dt_q    <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      ccnt_q  <= ccnt_d;
      ok_q    <= ok_d;
      dt_q    <= dt_d;
    end
  end

  // Fetch base and byte assembly are pure data, never consumed outside READ/DONE.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    asm_q  <= asm_d;
  end

  assign ok     = ok_q;
  assign dt     = dt_q;
  assign busy   = (state_q != IDLE);
  assign mem_rd = issue;
  assign mem_a  = issue ? (base_q + 32'(icnt_q)) : 32'h0;

endmodule

// File: tb/tb_ifetch_mem.sv
module tb_ifetch_mem;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] pc;
  logic        flush;
  logic        ok;
  logic [31:0] dt;
  logic        busy;
  logic [31:0] mem_a;
  logic        mem_rd;
  logic [7:0]  mem_din;

`ifdef IFETCH_LASTBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  ifetch_mem #(.RAM_LAT(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .pc      (pc),
    .flush   (flush),
    .ok      (ok),
    .dt      (dt),
    .busy    (busy),
    .mem_a   (mem_a),
    .mem_rd  (mem_rd),
    .mem_din (mem_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide synchronous-read instruction RAM (256 bytes, address wraps on low byte).
  logic [7:0] ram [256];
  always @(posedge clk) if (mem_rd) mem_din <= ram[mem_a[7:0]];

  typedef struct {
    logic [31:0] w;
    int          c;
  } okexp_t;

  okexp_t      okq[$];
  logic [31:0] addrq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rd_seen = 0;
  int rd_exp = 0;

  // Reference model state
  logic [31:0] exp_dt;
  bit          lb_valid;
  logic [31:0] lb_tag;
  logic [31:0] lb_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return ram[a[7:0]];
  endfunction

  // Monitor: every ok and every RAM read must match the next queued expectation.
  always @(negedge clk) begin
    okexp_t      e;
    logic [31:0] a;
    if (ok === 1'b1) begin
      if (okq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ok: got ok=1 dt=%h expected no ok (cycle %0d)", dt, cyc);
      end else begin
        e = okq.pop_front();
        check("ok_dt", dt, e.w);
        check("ok_cycle", 32'(cyc), 32'(e.c));
      end
    end
    if (mem_rd === 1'b1) begin
      rd_seen++;
      if (addrq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: got mem_rd=1 mem_a=%h expected no read (cycle %0d)", mem_a, cyc);
      end else begin
        a = addrq.pop_front();
        check("mem_a", mem_a, a);
      end
    end
  end

  // One request. fk: edge index (0 = acceptance edge) carrying flush, -1 none.
  // rk: edge index (1..6) carrying reset, -1 none. keep: hold req high afterwards.
  task automatic txn(input logic [31:0] p, input int fk, input int rk, input bit keep);
    logic [31:0] base;
    logic [31:0] word;
    int          c0;
    int          stop;
    int          nrd;
    bit          hit;
    base = {p[31:2], 2'b00};
    hit  = LB && lb_valid && (lb_tag == base);
    req   = 1'b1;
    pc    = p;
    flush = (fk == 0);
    @(posedge clk); #1;
    c0    = cyc;
    flush = 1'b0;
    if (fk == 0) begin
      req = keep;
      check("flushreq_busy", 32'(busy), 32'(0));
      check("flushreq_dt", dt, exp_dt);
      return;
    end
    if (hit) begin
      okq.push_back('{lb_word, c0});
      exp_dt = lb_word;
      req = keep;
      return;
    end
    word = {byte_at(base + 3), byte_at(base + 2), byte_at(base + 1), byte_at(base)};
    stop = (fk > 0) ? fk : ((rk > 0) ? rk : 7);
    nrd  = (stop < 4) ? stop : 4;
    for (int i = 0; i < nrd; i++) addrq.push_back(base + 32'(i));
    rd_exp += nrd;
    if (stop == 7) okq.push_back('{word, c0 + 6});
    req = keep;
    if (keep) pc = $urandom;
    for (int e = 1; e <= 6; e++) begin
      flush = (e == fk);
      rst   = !(e == rk);
      @(posedge clk); #1;
      flush = 1'b0;
      rst   = 1'b1;
      if (e == fk) begin
        check("flush_busy", 32'(busy), 32'(0));
        check("flush_mem_rd", 32'(mem_rd), 32'(0));
        check("flush_ok", 32'(ok), 32'(0));
        check("flush_dt", dt, exp_dt);
        return;
      end
      if (e == rk) begin
        lb_valid = 1'b0;
        exp_dt   = '0;
        check("rst_ok", 32'(ok), 32'(0));
        check("rst_dt", dt, 32'h0);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_rd", 32'(mem_rd), 32'(0));
        return;
      end
      if (e == 1) check("read_busy", 32'(busy), 32'(1));
    end
    check("done_busy", 32'(busy), 32'(0));
    exp_dt   = word;
    lb_valid = LB;
    lb_tag   = base;
    lb_word  = word;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          fk;
    int          rk;
    logic [31:0] p;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h93; ram[1] = 8'h60; ram[2] = 8'hB0; ram[3] = 8'h07;
    ram[4] = 8'h13; ram[5] = 8'h61; ram[6] = 8'h90; ram[7] = 8'h0E;
    exp_dt   = '0;
    lb_valid = 1'b0;
    lb_tag   = '0;
    lb_word  = '0;
    rst   = 1'b0;
    req   = 1'b0;
    flush = 1'b0;
    pc    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ok", 32'(ok), 32'(0));
    check("reset_dt", dt, 32'h0);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_mem_a", mem_a, 32'h0);
    check("reset_mem_rd", 32'(mem_rd), 32'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic fetch followed by back-to-back requests with req held high.
    txn(32'h0, -1, -1, 1'b1);
    check("basic_dt", dt, 32'h07B06093);
    txn(32'h4, -1, -1, 1'b1);
    check("b2b_dt", dt, 32'h0E906113);
    txn(32'h7, -1, -1, 1'b0);
    check("b2b_low_bits_dt", dt, 32'h0E906113);
    repeat (2) @(posedge clk);
    #1;

    // Flush on the third READ edge, then a normal fetch at 8.
    txn(32'h20, 3, -1, 1'b0);
    txn(32'h8, -1, -1, 1'b0);

    // Reset mid-fetch; no ok must follow.
    txn(32'h30, -1, 3, 1'b0);
    repeat (8) @(posedge clk);
    #1;

    // Flush on the DONE edge, then flush together with req in IDLE.
    txn(32'h40, 6, -1, 1'b0);
    txn(32'h44, 0, -1, 1'b0);

    // Address wrap at the top of memory.
    txn(32'hFFFF_FFFC, -1, -1, 1'b0);

    // Repeated fetch at 0x0C with RAM changed in between, then 0x10.
    txn(32'hC, -1, -1, 1'b0);
    ram[8'h0C] = ~ram[8'h0C];
    txn(32'hC, -1, -1, 1'b0);
    txn(32'h10, -1, -1, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) ram[$urandom_range(0, 63)] = 8'($urandom);
      p = {26'($urandom_range(0, 15)), 4'h0, 2'($urandom)};
      p[3:2] = 2'($urandom);
      if ($urandom_range(0, 15) == 0) p = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      fk = -1;
      rk = -1;
      case ($urandom_range(0, 9))
        0: fk = $urandom_range(0, 6);
        1: rk = $urandom_range(1, 6);
        default: ;
      endcase
      txn(p, fk, rk, 1'($urandom));
    end
    req = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    check("ok_queue_empty", 32'(okq.size()), 32'(0));
    check("addr_queue_empty", 32'(addrq.size()), 32'(0));
    check("read_count", 32'(rd_seen), 32'(rd_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
